// File: rtl/mac_dot_ctrl.sv
// rtl/mac_dot_ctrl.sv - AHB-lite configured dot-product sequencer feeding the shared FP MAC core
module mac_dot_ctrl #(
    parameter int AW = 10,
    parameter int LW = 16
) (
    input  logic          hclk,
    input  logic          rst_n,
    input  logic          hsel,
    input  logic          hwrite,
    input  logic          hready_i,
    input  logic [1:0]    htrans,
    input  logic [31:0]   haddr,
    input  logic [31:0]   hwdata,
    output logic [31:0]   hrdata,
    output logic          hready_o,
    output logic          hresp,
    output logic          a_en,
    output logic          b_en,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    input  logic [31:0]   a_rdata,
    input  logic [31:0]   b_rdata,
    output logic          mac_valid,
    input  logic          mac_ready,
    output logic [31:0]   mac_a,
    output logic [31:0]   mac_b,
    output logic          mac_clr,
    input  logic          mac_idle,
    input  logic [31:0]   mac_acc,
    output logic          irq
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state;
    logic          wr_q;
    logic          rd_q;
    logic [2:0]    addr_q;
    logic          irq_en;
    logic          done;
    logic [AW-1:0] a_base;
    logic [AW-1:0] b_base;
    logic [LW-1:0] len;
    logic [31:0]   result;
    logic [LW-1:0] rd_cnt;
    logic [LW-1:0] acc_cnt;

    logic [63:0]   fifo_mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    cnt;
    logic          rvalid;

    logic          busy;
    logic          wr_ctrl;
    logic          wr_stat;
    logic          start_req;
    logic          do_abort;
    logic          pop;
    logic          pop_mem;
    logic          push;
    logic          issue;
    logic [2:0]    occ;
    logic [2:0]    lim;
    logic [63:0]   incoming;
    logic [63:0]   head;
    logic          unused_bits;

    assign hready_o = 1'b1;
    assign hresp    = 1'b0;
    assign busy     = (state != S_IDLE);
    assign irq      = done & irq_en;

    assign wr_ctrl   = wr_q && (addr_q == 3'd0);
    assign wr_stat   = wr_q && (addr_q == 3'd1);
    assign start_req = wr_ctrl && hwdata[0] && !hwdata[2];
    assign do_abort  = wr_ctrl && hwdata[2] && busy;

    // The SRAM output register acts as a bypass stage in front of the 2-entry FIFO
    assign incoming  = {a_rdata, b_rdata};
    assign head      = (cnt != 2'd0) ? fifo_mem[rd_ptr] : incoming;
    assign mac_valid = (cnt != 2'd0) || rvalid;
    assign mac_a     = mac_valid ? head[63:32] : 32'h0;
    assign mac_b     = mac_valid ? head[31:0]  : 32'h0;
    assign pop       = mac_valid && mac_ready;
    assign pop_mem   = pop && (cnt != 2'd0);
    assign push      = rvalid && !((cnt == 2'd0) && pop);

    assign occ   = {1'b0, cnt} + {2'b00, rvalid};
    assign lim   = 3'd2 + {2'b00, pop};
    assign issue = (state == S_STREAM) && (rd_cnt < len) && (occ < lim);

    assign a_en   = issue;
    assign b_en   = issue;
    assign a_addr = a_base + rd_cnt[AW-1:0];
    assign b_addr = b_base + rd_cnt[AW-1:0];

    assign unused_bits = ^{haddr[31:5], haddr[1:0], htrans[0], hwdata[31:LW]};

    always_ff @(posedge hclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            addr_q <= 3'd0;
        end else begin
            wr_q   <= hsel && hready_i && htrans[1] && hwrite;
            rd_q   <= hsel && hready_i && htrans[1] && !hwrite;
            addr_q <= haddr[4:2];
        end
    end

    always_comb begin
        hrdata = 32'h0;
        if (rd_q) begin
            case (addr_q)
                3'd0:    hrdata[1]   = irq_en;
                3'd1:    hrdata[1:0] = {done, busy};
                3'd2:    hrdata      = 32'(a_base);
                3'd3:    hrdata      = 32'(b_base);
                3'd4:    hrdata      = 32'(len);
                3'd5:    hrdata      = result;
                default: hrdata      = 32'h0;
            endcase
        end
    end

    always_ff @(posedge hclk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            mac_clr <= 1'b0;
            irq_en  <= 1'b0;
            done    <= 1'b0;
            a_base  <= '0;
            b_base  <= '0;
            len     <= '0;
            result  <= 32'h0;
            rd_cnt  <= '0;
            acc_cnt <= '0;
        end else begin
            mac_clr <= 1'b0;
            if (wr_ctrl) irq_en <= hwdata[1];
            if (wr_q && !busy) begin
                if (addr_q == 3'd2) a_base <= hwdata[AW-1:0];
                if (addr_q == 3'd3) b_base <= hwdata[AW-1:0];
                if (addr_q == 3'd4) len    <= hwdata[LW-1:0];
            end
            if (wr_stat && hwdata[1]) done <= 1'b0;
            if (do_abort) begin
                state   <= S_IDLE;
                mac_clr <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_req) begin
                            state   <= S_CLR;
                            mac_clr <= 1'b1;
                            done    <= 1'b0;
                        end
                    end
                    S_CLR: begin
                        rd_cnt  <= '0;
                        acc_cnt <= '0;
                        state   <= (len == '0) ? S_DONE : S_STREAM;
                    end
                    S_STREAM: begin
                        if (issue) rd_cnt <= rd_cnt + LW'(1);
                        if (pop) begin
                            acc_cnt <= acc_cnt + LW'(1);
                            if (acc_cnt + LW'(1) == len) state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (mac_idle) state <= S_DONE;
                    end
                    S_DONE: begin
                        result <= (len == '0) ? 32'h0 : mac_acc;
                        done   <= 1'b1;
                        state  <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge hclk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0] <= 64'h0;
            fifo_mem[1] <= 64'h0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            cnt         <= 2'd0;
            rvalid      <= 1'b0;
        end else if (do_abort) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= issue;
            if (push) begin
                fifo_mem[wr_ptr] <= incoming;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop_mem) rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, push} - {1'b0, pop_mem};
        end
    end

endmodule

// File: doc/mac_dot_ctrl.md
# mac_dot_ctrl

AHB-lite-configured sequencer that runs a complete dot product on the shared floating-point MAC core without CPU involvement per element. The CPU programs two operand base addresses and a length, then writes start. The block streams operand pairs from the feature and weight SRAMs into the MAC core with a valid/ready handshake, waits for the MAC pipeline to drain, latches the accumulated result, and raises a done flag and an optional interrupt. It sits between the Cortex-M3 AHB bus and the MAC core, and replaces per-element register writes for CNN and MFCC inner loops.

## Interface
Parameters:
- AW, 10, SRAM word-address width for both operand buffers
- LW, 16, width of the length register

Ports:
- hclk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- hsel, hwrite, hready_i  in  1  AHB-lite slave select / write / bus ready
- htrans  in  2  AHB transfer type; only NONSEQ and SEQ are acted on
- haddr  in  32  byte address; bits [4:2] decoded
- hwdata  in  32  write data (data phase)
- hrdata  out  32  read data
- hready_o  out  1  always 1 (zero wait)
- hresp  out  1  always 0 (OKAY)
- a_en, b_en  out  1  SRAM read enables
- a_addr, b_addr  out  AW  SRAM word addresses
- a_rdata, b_rdata  in  32  SRAM read data; valid 1 cycle after the enable
- mac_valid  out  1  operand pair valid
- mac_ready  in  1  MAC core accepts the pair this cycle
- mac_a, mac_b  out  32  IEEE-754 single-precision operands
- mac_clr  out  1  one-cycle pulse that zeroes the accumulator
- mac_idle  in  1  MAC pipeline empty; mac_acc is final
- mac_acc  in  32  accumulator value
- irq  out  1  level interrupt = done & irq_en

## Operation
- Register map (word offsets):
  - 0x00 CTRL: bit0 start (write-1, self-clearing), bit1 irq_en (RW), bit2 abort (write-1)
  - 0x04 STATUS: bit0 busy (RO), bit1 done (sticky, write-1-to-clear)
  - 0x08 A_BASE [AW-1:0] (RW)
  - 0x0C B_BASE (RW)
  - 0x10 LEN [LW-1:0] (RW)
  - 0x14 RESULT (RO)
  - Unmapped offsets read 0; writes to them are ignored.
- Address phase is registered when hsel & hready_i & htrans[1]. The write takes effect with hwdata on the following cycle. Read data is driven combinationally in the data phase.
- Writes to A_BASE, B_BASE and LEN while busy are ignored.
- FSM states:
  - IDLE: start → CLR; start also clears done.
  - CLR: mac_clr=1 for one cycle, element counters reset → IDLE-to-DONE if LEN==0, else STREAM.
  - STREAM: issue SRAM reads and push pairs into the MAC → DRAIN when LEN pairs have been accepted.
  - DRAIN: wait for mac_idle=1 → DONE.
  - DONE: RESULT ← mac_acc, done ← 1 for one cycle → IDLE.
- The LEN==0 path goes CLR → DONE and yields RESULT=0x00000000.
- Issue path:
  - Keep a 2-entry operand FIFO and a count of outstanding reads.
  - Issue a read (a_en=b_en=1, addr = base + rd_cnt) when rd_cnt < LEN and occupancy + outstanding − pop < 2. pop = mac_valid & mac_ready.
  - mac_valid = FIFO non-empty; mac_a/mac_b = FIFO head.
- Address arithmetic wraps modulo 2^AW.
- Counters are LW bits wide and compare against LEN as an unsigned value.
- Start while busy is ignored.
- Abort (any state except IDLE):
  - Go to IDLE next cycle, flush the FIFO, discard outstanding read data, pulse mac_clr.
  - done is not set and RESULT is unchanged.
- Start and abort in the same write: abort wins, no new run.
- Write-1-to-clear of done in the same cycle as DONE sets it: set wins.

## Timing
- Reset values: all registers 0, FSM IDLE, busy=0, done=0, irq=0. Outputs a_en=b_en=0, a_addr=b_addr=0, mac_valid=0, mac_clr=0, mac_a=mac_b=0. hrdata=0, hready_o=1, hresp=0.
- Start write data phase at cycle T: CLR at T+1, first read at T+2, first mac_valid at T+3.
- With mac_ready held at 1, one pair per cycle: last pair accepted at T+2+LEN.
- DONE follows one cycle after the first cycle in DRAIN where mac_idle=1. done and RESULT are visible to a read whose data phase starts the cycle after DONE.
- busy=1 from CLR through DONE inclusive.
- Reset asserted mid-run returns everything to reset values immediately. No mac_clr pulse is produced by reset.

## Test plan
- LEN=10, A and B buffers all 0x3F000000 (0.5), mac_ready=1 → 10 accepts in 10 consecutive cycles, RESULT=0x40200000 (2.5), done=1. A second identical run also gives 0x40200000, which confirms mac_clr.
- Same data with mac_ready toggling 1,0,0,1 randomly → exactly 10 accepts, no duplicated or dropped pairs, a_addr sequence strictly base..base+9, RESULT 0x40200000.
- LEN=0 start → mac_clr pulse, zero mac_valid cycles, done=1 within 3 cycles, RESULT=0x00000000.
- A_BASE=2^AW−2, LEN=4 → a_addr sequence 0x3FE,0x3FF,0x000,0x001.
- Abort after 3 accepts of a LEN=10 run → busy=0 next cycle, done=0, RESULT unchanged, mac_clr pulse. A subsequent start completes normally.
- irq_en=1, run to completion → irq=1. Write 0x2 to STATUS → irq=0. Start while busy and a LEN write while busy → no effect on the current run.
